// File: rtl/aes_out_pack512.sv
// aes_out_pack512: packs four 128-bit AES blocks per 512-bit word into a valid/ready FIFO.
// Define AES_PACK_FLUSH_EN to add i_flush/o_out_keep for emitting partial groups.
module aes_out_pack512 #(
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    input  logic [127:0]           i_in_data,
`ifdef AES_PACK_FLUSH_EN
    input  logic                   i_flush,
    output logic [3:0]             o_out_keep,
`endif
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [511:0]           o_out_data,
    output logic                   o_almost_full,
    output logic [$clog2(DEPTH):0] o_fill_count,
    output logic                   o_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]    r_cnt;
    logic [383:0]  r_pack;
    logic [511:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_fill;
    logic          r_overflow;

    logic          w_last;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic [1:0]    w_cnt_adv;
    logic [1:0]    w_cnt_next;
    logic [383:0]  w_pack_next;
    logic [511:0]  w_word;

    // Lanes above the current count are always zero because the packer clears on every push.
    always_comb begin
        w_pack_next = r_pack;
        if (i_in_valid && r_cnt != 2'd3)
            w_pack_next[r_cnt*128 +: 128] = i_in_data;
    end

    assign w_last    = i_in_valid && r_cnt == 2'd3;
    assign w_cnt_adv = r_cnt + {1'b0, i_in_valid};
    assign w_word    = {w_last ? i_in_data : 128'd0, w_pack_next};

`ifdef AES_PACK_FLUSH_EN
    logic       w_flush_push;
    logic [3:0] w_keep;
    logic [3:0] r_keep [DEPTH];

    assign w_flush_push = i_flush && w_cnt_adv != 2'd0;
    assign w_push       = w_last || w_flush_push;
    assign w_cnt_next   = w_flush_push ? 2'd0 : w_cnt_adv;
    assign w_keep       = w_last ? 4'hF : (4'd1 << w_cnt_adv) - 4'd1;
    assign o_out_keep   = o_out_valid ? r_keep[r_rd] : 4'd0;

    always_ff @(posedge i_clk)
        if (w_wr)
            r_keep[r_wr] <= w_keep;
`else
    assign w_push     = w_last;
    assign w_cnt_next = w_cnt_adv;
`endif

    assign w_full = r_fill == CW'(DEPTH);
    assign w_pop  = o_out_valid && i_out_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly the tail being written.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= 2'd0;
            r_pack     <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_pack <= w_push ? '0 : w_pack_next;
            if (w_wr)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_fill <= (w_wr && !w_pop) ? r_fill + 1'b1 :
                      (w_pop && !w_wr) ? r_fill - 1'b1 : r_fill;
            if (w_push && !w_wr)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk)
        if (w_wr)
            r_mem[r_wr] <= w_word;

    assign o_out_valid   = r_fill != '0;
    assign o_out_data    = o_out_valid ? r_mem[r_rd] : 512'd0;
    assign o_almost_full = r_fill >= CW'(AFULL_THRESH);
    assign o_fill_count  = r_fill;
    assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_aes_out_pack512.sv
// tb_aes_out_pack512: directed checks of packing, FIFO ordering, full/overflow and reset.
module tb_aes_out_pack512;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic         almost_full;
    logic [3:0]   fill_count;
    logic         overflow;
    int           pass_cnt = 0;
    int           total = 0;
`ifdef AES_PACK_FLUSH_EN
    logic         flush;
    logic [3:0]   out_keep;
`endif

    always #5 clk = ~clk;

    aes_out_pack512 #(.DEPTH(8), .AFULL_THRESH(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (in_valid),
        .i_in_data     (in_data),
`ifdef AES_PACK_FLUSH_EN
        .i_flush       (flush),
        .o_out_keep    (out_keep),
`endif
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_almost_full (almost_full),
        .o_fill_count  (fill_count),
        .o_overflow    (overflow)
    );

    function automatic logic [127:0] blk(input int n);
        return {32'hC0DE0000 + 32'(n), 32'(n) * 32'd7, 32'hA5A5A5A5, 32'(n)};
    endfunction

    function automatic logic [511:0] w4(input int a);
        return {blk(a + 3), blk(a + 2), blk(a + 1), blk(a)};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic gap_pat [12] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1};
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES_PACK_FLUSH_EN
        flush = 1'b0;
`endif
        tick();
        tick();
        chk("rst_valid", 512'(out_valid), 512'(0));
        chk("rst_data", out_data, 512'd0);
        chk("rst_afull", 512'(almost_full), 512'(0));
        chk("rst_fill", 512'(fill_count), 512'(0));
        chk("rst_ovf", 512'(overflow), 512'(0));
        rst_n = 1'b1;

        // back-to-back group with consumer ready
        out_ready = 1'b1;
        send(blk(1));
        send(blk(2));
        send(blk(3));
        chk("t1_no_early_valid", 512'(out_valid), 512'(0));
        send(blk(4));
        chk("t1_valid", 512'(out_valid), 512'(1));
        chk("t1_data", out_data, w4(1));
        chk("t1_lane0", 512'(out_data[127:0]), 512'(blk(1)));
        chk("t1_lane3", 512'(out_data[511:384]), 512'(blk(4)));
        tick();
        chk("t1_fill_zero", 512'(fill_count), 512'(0));
        chk("t1_valid_drop", 512'(out_valid), 512'(0));

        // gapped input, consumer stalled
        out_ready = 1'b0;
        k = 10;
        for (int i = 0; i < 12; i++) begin
            if (gap_pat[i]) begin
                send(blk(k));
                k++;
            end else
                tick();
        end
        chk("t2_fill", 512'(fill_count), 512'(2));
        chk("t2_word0", out_data, w4(10));
        out_ready = 1'b1;
        tick();
        chk("t2_word1", out_data, w4(14));
        chk("t2_fill1", 512'(fill_count), 512'(1));
        tick();
        chk("t2_fill0", 512'(fill_count), 512'(0));
        out_ready = 1'b0;

        // fill to capacity, then overflow
        for (int i = 0; i < 32; i++) begin
            send(blk(100 + i));
            if (i == 11)
                chk("t3_afull_3w", 512'(almost_full), 512'(0));
            if (i == 15)
                chk("t3_afull_4w", 512'(almost_full), 512'(1));
        end
        chk("t3_fill_full", 512'(fill_count), 512'(8));
        chk("t3_no_ovf", 512'(overflow), 512'(0));
        for (int i = 0; i < 4; i++)
            send(blk(200 + i));
        chk("t3_ovf", 512'(overflow), 512'(1));
        chk("t3_fill_hold", 512'(fill_count), 512'(8));
        chk("t3_head", out_data, w4(100));

        // push and pop together while full
        send(blk(300));
        send(blk(301));
        send(blk(302));
        out_ready = 1'b1;
        send(blk(303));
        out_ready = 1'b0;
        chk("t4_fill", 512'(fill_count), 512'(8));
        chk("t4_head", out_data, w4(104));
        out_ready = 1'b1;
        for (int w = 1; w < 8; w++) begin
            chk($sformatf("t3_drain%0d", w), out_data, w4(100 + 4 * w));
            tick();
        end
        chk("t4_tail", out_data, w4(300));
        tick();
        chk("t3_drained", 512'(fill_count), 512'(0));
        chk("t3_ovf_sticky", 512'(overflow), 512'(1));
        out_ready = 1'b0;

        // reset mid-group
        send(blk(400));
        send(blk(401));
        send(blk(402));
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = blk(499);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        chk("t5_fill_rst", 512'(fill_count), 512'(0));
        chk("t5_ovf_rst", 512'(overflow), 512'(0));
        send(blk(500));
        send(blk(501));
        send(blk(502));
        chk("t5_partial", 512'(out_valid), 512'(0));
        send(blk(503));
        chk("t5_word", out_data, w4(500));
        chk("t5_fill", 512'(fill_count), 512'(1));
        out_ready = 1'b1;
        tick();
        chk("t5_empty", 512'(out_valid), 512'(0));
        out_ready = 1'b0;

`ifdef AES_PACK_FLUSH_EN
        send(blk(600));
        send(blk(601));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_word", out_data, {256'd0, blk(601), blk(600)});
        chk("t6_keep", 512'(out_keep), 512'(4'b0011));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        send(blk(700));
        flush = 1'b0;
        chk("t6_vflush_word", out_data, {384'd0, blk(700)});
        chk("t6_vflush_keep", 512'(out_keep), 512'(4'b0001));
        chk("t6_fill", 512'(fill_count), 512'(1));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
